// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front end: BCD width, the "no key"
// code, the debounce state encoding and the keypad priority encoder.
package keypad_pkg;

  localparam int              BCD_W  = 4;
  localparam logic [BCD_W-1:0] NO_KEY = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    HELD,
    RELEASE
  } deb_state_e;

  // Highest-index pressed key wins; no key pressed gives NO_KEY.
  function automatic logic [BCD_W-1:0] key_encode(input logic [9:0] keys);
    logic [BCD_W-1:0] code;
    code = NO_KEY;
    for (int k = 0; k < 10; k++) begin
      if (keys[k]) code = BCD_W'(k);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Key debounce FSM with optional auto-repeat (macro KEYPAD_REPEAT_EN).
// Produces a one-cycle accept together with the candidate code.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no key being tracked, waiting for any key
// CHECK   | candidate latched, counting consecutive stable samples
// HELD    | key accepted and still down (repeat timer runs if enabled)
// RELEASE | key lifted, waiting for a stable no-key period
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 8,
  parameter int REPEAT_CYC   = 64
) (
  input  logic             clock_i,
  input  logic             clearn_i,
  input  logic             en_i,
  input  logic [BCD_W-1:0] code_i,
  output logic             accept_o,
  output logic [BCD_W-1:0] cand_o
);

  localparam int           DW       = $clog2(DEBOUNCE_CYC);
  // The sample that moves IDLE->CHECK is the first stable one, so the
  // counter only has to cover the remaining DEBOUNCE_CYC-1 samples.
  localparam logic [DW-1:0] CHK_LAST = DW'(DEBOUNCE_CYC - 2);
  localparam logic [DW-1:0] REL_LAST = DW'(DEBOUNCE_CYC - 2);

  deb_state_e       state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0] cand_q, cand_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int           RW       = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] rpt_q, rpt_d;

  // Auto-repeat timer register.
  always_ff @(posedge clock_i or negedge clearn_i) begin
    if (!clearn_i) rpt_q <= '0;
    else           rpt_q <= rpt_d;
  end
`endif

  // FSM state, debounce counter and candidate code registers.
  always_ff @(posedge clock_i or negedge clearn_i) begin
    if (!clearn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= NO_KEY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Next-state logic and accept generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_o = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d    = rpt_q;
`endif
    if (en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (code_i != NO_KEY) begin
            state_d = CHECK;
            cand_d  = code_i;
            cnt_d   = '0;
          end
        end
        CHECK: begin
          if (code_i == cand_q) begin
            if (cnt_q == CHK_LAST) begin
              state_d  = HELD;
              accept_o = 1'b1;
              cnt_d    = '0;
`ifdef KEYPAD_REPEAT_EN
              rpt_d    = '0;
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (code_i == NO_KEY) begin
            state_d = RELEASE;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_d   = '0;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            // Only an unbroken hold of the accepted key repeats.
            if (code_i == cand_q) begin
              if (rpt_q == RPT_LAST) begin
                accept_o = 1'b1;
                rpt_d    = '0;
              end else begin
                rpt_d = rpt_q + 1'b1;
              end
            end else begin
              rpt_d = '0;
            end
`endif
          end
        end
        RELEASE: begin
          if (code_i != NO_KEY) begin
            state_d = HELD;
          end else if (cnt_q == REL_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cand_o = cand_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad front end for the timer datapath: debounce + BCD encode, digit
// entry register, and the pgt_tick timing output (key strobe in entry
// mode, divided clock in run mode). Build option KEYPAD_REPEAT_EN enables
// auto-repeat in the debouncer.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 8,
  parameter int PULSE_LEN    = 8,
  parameter int TICK_DIV     = 100,
  parameter int REPEAT_CYC   = 64
) (
  input  logic                         clock_i,
  input  logic                         clearn_i,
  input  logic                         en_i,
  input  logic [9:0]                   keypad_i,
  input  logic                         clear_entry_i,
  output logic [BCD_W-1:0]             bcd_o,
  output logic                         key_valid_o,
  output logic [4*DIGITS-1:0]          entry_o,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count_o,
  output logic                         overflow_o,
  output logic                         pgt_tick_o
);

  localparam int            CW         = $clog2(DIGITS + 1);
  localparam int            PW         = $clog2(PULSE_LEN + 1);
  localparam int            VW         = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DIGITS);
  localparam logic [PW-1:0] PULSE_INIT = PW'(PULSE_LEN);
  localparam logic [VW-1:0] DIV_LAST   = VW'(TICK_DIV - 1);

  logic [BCD_W-1:0]    code;
  logic                accept;
  logic [BCD_W-1:0]    cand;
  logic                take;

  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                key_valid_q, key_valid_d;
  logic [4*DIGITS-1:0] entry_q, entry_d, entry_shift;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [PW-1:0]       pulse_q, pulse_d;
  logic [VW-1:0]       div_q, div_d;

  assign code = key_encode(keypad_i);

  key_debouncer #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) u_deb (
    .clock_i  (clock_i),
    .clearn_i (clearn_i),
    .en_i     (en_i),
    .code_i   (code),
    .accept_o (accept),
    .cand_o   (cand)
  );

  if (DIGITS == 1) begin : g_one_digit
    assign entry_shift = cand;
  end else begin : g_multi_digit
    assign entry_shift = {entry_q[4*DIGITS-5:0], cand};
  end

  // A clear in the same cycle discards the accept entirely.
  assign take = accept & ~clear_entry_i;

  // Entry register, strobe counter and run-mode divider next state.
  always_comb begin
    bcd_d       = bcd_q;
    key_valid_d = take;
    entry_d     = entry_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    pulse_d     = pulse_q;
    div_d       = div_q;

    if (clear_entry_i) begin
      entry_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (take) begin
      bcd_d   = cand;
      entry_d = entry_shift;
      if (count_q == CNT_FULL) ovf_d   = 1'b1;
      else                     count_d = count_q + 1'b1;
    end

    if (en_i)                pulse_d = '0;
    else if (take)           pulse_d = PULSE_INIT;
    else if (pulse_q != '0)  pulse_d = pulse_q - 1'b1;

    if (!en_i)                div_d = '0;
    else if (div_q == DIV_LAST) div_d = '0;
    else                     div_d = div_q + 1'b1;
  end

  // Output and counter registers.
  always_ff @(posedge clock_i or negedge clearn_i) begin
    if (!clearn_i) begin
      bcd_q       <= NO_KEY;
      key_valid_q <= 1'b0;
      entry_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      pulse_q     <= '0;
      div_q       <= '0;
    end else begin
      bcd_q       <= bcd_d;
      key_valid_q <= key_valid_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      pulse_q     <= pulse_d;
      div_q       <= div_d;
    end
  end

  assign bcd_o         = bcd_q;
  assign key_valid_o   = key_valid_q;
  assign entry_o       = entry_q;
  assign digit_count_o = count_q;
  assign overflow_o    = ovf_q;
  assign pgt_tick_o    = en_i ? (div_q == DIV_LAST) : (pulse_q != '0);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl (default parameters).
module tb_keypad_entry_ctrl;

  logic        clk;
  logic        clearn;
  logic        en;
  logic [9:0]  keypad;
  logic        clear_entry;
  logic [3:0]  bcd;
  logic        key_valid;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        pgt_tick;

  keypad_entry_ctrl #(
    .DIGITS       (4),
    .DEBOUNCE_CYC (8),
    .PULSE_LEN    (8),
    .TICK_DIV     (100),
    .REPEAT_CYC   (64)
  ) dut (
    .clock_i       (clk),
    .clearn_i      (clearn),
    .en_i          (en),
    .keypad_i      (keypad),
    .clear_entry_i (clear_entry),
    .bcd_o         (bcd),
    .key_valid_o   (key_valid),
    .entry_o       (entry),
    .digit_count_o (digit_count),
    .overflow_o    (overflow),
    .pgt_tick_o    (pgt_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  bcd;
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_key(input logic [3:0] b, input logic [15:0] e,
                            input logic [2:0] c, input logic o, input int at);
    exp_t x;
    x.bcd = b; x.entry = e; x.cnt = c; x.ovf = o; x.at = at;
    exp_q.push_back(x);
  endtask

  // Monitor: every key_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (clearn && key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_accept: got key_valid bcd=%0h entry=%0h at cycle %0d, expected none",
                 bcd, entry, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("accept_cycle", cyc, mon_e.at);
        check("accept_bcd", bcd, mon_e.bcd);
        check("accept_entry", entry, mon_e.entry);
        check("accept_count", digit_count, mon_e.cnt);
        check("accept_overflow", overflow, mon_e.ovf);
      end
    end
  end

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key_entry(input int k, input logic [15:0] e, input logic [2:0] c, input logic o);
    logic [9:0] m;
    m = 10'd1 << k;
    expect_key(4'(k), e, c, o, cyc + 8);
    keypad = m;
    tick(12);
    keypad = '0;
    tick(12);
  endtask

  task automatic do_clear();
    clear_entry = 1'b1;
    tick(1);
    clear_entry = 1'b0;
  endtask

  initial begin
    logic [9:0] m;
    clearn = 1'b0; en = 1'b0; keypad = '0; clear_entry = 1'b0;
    #23;
    check("rst_bcd", bcd, 4'hF);
    check("rst_entry", entry, 16'h0);
    check("rst_count", digit_count, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_pgt", pgt_tick, 1'b0);
    clearn = 1'b1;
    tick(2);

    // Key 5: 8-cycle latency, 8-cycle strobe.
    expect_key(4'd5, 16'h0005, 3'd1, 1'b0, cyc + 8);
    keypad = 10'd1 << 5;
    tick(7);
    check("pgt_before_accept", pgt_tick, 1'b0);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      check("pgt_strobe_high", pgt_tick, 1'b1);
      tick(1);
    end
    check("pgt_strobe_end", pgt_tick, 1'b0);
    keypad = '0;
    tick(12);

    // Key 3 bouncing, then stable: a single accept 8 cycles into the stable phase.
    m = 10'd1 << 3;
    for (int r = 0; r < 3; r++) begin
      keypad = m;  tick(3);
      keypad = '0; tick(1);
    end
    expect_key(4'd3, 16'h0053, 3'd2, 1'b0, cyc + 8);
    keypad = m;
    tick(12);
    keypad = '0;
    tick(12);

    // Five digits into a four-digit register.
    do_clear();
    check("clear_entry0", entry, 16'h0);
    key_entry(1, 16'h0001, 3'd1, 1'b0);
    key_entry(2, 16'h0012, 3'd2, 1'b0);
    key_entry(3, 16'h0123, 3'd3, 1'b0);
    key_entry(4, 16'h1234, 3'd4, 1'b0);
    key_entry(5, 16'h2345, 3'd4, 1'b1);
    check("full_entry", entry, 16'h2345);
    check("full_count", digit_count, 3'd4);
    check("full_overflow", overflow, 1'b1);
    do_clear();
    check("clr_entry", entry, 16'h0);
    check("clr_count", digit_count, 3'd0);
    check("clr_overflow", overflow, 1'b0);
    check("clr_keeps_bcd", bcd, 4'd5);

    // Keys 2 and 7 together: priority to 7.
    expect_key(4'd7, 16'h0007, 3'd1, 1'b0, cyc + 8);
    keypad = (10'd1 << 2) | (10'd1 << 7);
    tick(12);
    keypad = '0;
    tick(12);

    // Key 8 accepted while clear_entry is high: discarded.
    keypad = 10'd1 << 8;
    tick(5);
    clear_entry = 1'b1;
    tick(5);
    clear_entry = 1'b0;
    tick(4);
    keypad = '0;
    tick(12);
    check("clr_accept_entry", entry, 16'h0);
    check("clr_accept_count", digit_count, 3'd0);
    check("clr_accept_bcd", bcd, 4'd7);

    key_entry(6, 16'h0006, 3'd1, 1'b0);

    // Run mode: tick at cycles 100, 200, 300; key presses ignored.
    en = 1'b1;
    check("run_pgt_start", pgt_tick, 1'b0);
    for (int k = 1; k <= 300; k++) begin
      if (k == 150) keypad = 10'd1 << 4;
      if (k == 175) keypad = '0;
      tick(1);
      check("run_tick", pgt_tick, (k % 100 == 99) ? 1'b1 : 1'b0);
    end
    check("run_entry_kept", entry, 16'h0006);
    en = 1'b0;
    tick(12);
    check("back_entry", entry, 16'h0006);
    check("back_count", digit_count, 3'd1);
    check("back_pgt", pgt_tick, 1'b0);

    // Long hold of key 9 for 8+64*3 cycles.
    do_clear();
    begin
      int c0;
      c0 = cyc;
`ifdef KEYPAD_REPEAT_EN
      expect_key(4'd9, 16'h0009, 3'd1, 1'b0, c0 + 8);
      expect_key(4'd9, 16'h0099, 3'd2, 1'b0, c0 + 72);
      expect_key(4'd9, 16'h0999, 3'd3, 1'b0, c0 + 136);
      expect_key(4'd9, 16'h9999, 3'd4, 1'b0, c0 + 200);
`else
      expect_key(4'd9, 16'h0009, 3'd1, 1'b0, c0 + 8);
`endif
      keypad = 10'd1 << 9;
      tick(200);
      keypad = '0;
      tick(20);
    end
`ifdef KEYPAD_REPEAT_EN
    check("hold_entry", entry, 16'h9999);
`else
    check("hold_entry", entry, 16'h0009);
`endif

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Parametrised keypad front end for the timer datapath.
- Debounces a one-hot-per-key keypad and encodes the accepted key to BCD.
- Assembles accepted digits into a multi-digit entry register.
- Drives a single positive-going timing output, pgt_tick: the key strobe pulse in entry mode, or a divided clock tick in run mode.
- Sits between the raw keypad pins and the load/count logic of the timer.

Parameters:
- DIGITS, 4, number of BCD digits held in the entry register (≥1).
- DEBOUNCE_CYC, 8, consecutive stable cycles required before a key is accepted (≥2).
- PULSE_LEN, 8, length in cycles of the pgt_tick strobe emitted per accepted key in entry mode (≥1).
- TICK_DIV, 100, clock division ratio of the run-mode tick (≥2).
- REPEAT_CYC, 64, auto-repeat period in cycles; used only with KEYPAD_REPEAT_EN.

Ports:
- clock, input, 1, system clock; all state changes on the rising edge.
- clearn, input, 1, asynchronous active-low reset.
- en, input, 1, mode select: 0 = entry mode, 1 = run mode.
- keypad, input, 10, raw key lines; bit k high = key k pressed.
- clear_entry, input, 1, synchronous clear of the entry register, count and overflow flag.
- bcd, output, 4, BCD code of the last accepted key.
- key_valid, output, 1, one-cycle pulse on each accepted key.
- entry, output, 4*DIGITS, assembled digits; the newest digit is in bits [3:0].
- digit_count, output, $clog2(DIGITS+1), number of valid digits in entry; saturates at DIGITS.
- overflow, output, 1, sticky flag: a digit was shifted out of entry.
- pgt_tick, output, 1, timing output (see Behaviour).

Behaviour:
Reset (clearn=0, asynchronous):
- All outputs go to 0, except bcd, which goes to 4'hF.
- The FSM goes to IDLE; all counters clear.

Key encode (combinational, internal):
- Highest-index pressed key wins.
- No key pressed produces NO_KEY (4'hF).

Debounce FSM, evaluated only when en=0:
- IDLE: code≠NO_KEY → go to CHECK, latch cand=code, clear counter.
- CHECK: code==cand → counter increments; when counter reaches DEBOUNCE_CYC-1 → go to HELD and accept. code≠cand → return to IDLE. A different key is never accepted directly; it must pass through IDLE.
- HELD: code==NO_KEY → go to RELEASE and clear counter; otherwise stay in HELD.
- RELEASE: code stays NO_KEY for DEBOUNCE_CYC cycles → go to IDLE. Any key seen → return to HELD.
- Minimum latency from a stable press to key_valid is DEBOUNCE_CYC cycles.

Accept (one cycle):
- key_valid=1 and bcd←cand.
- entry←{entry[4*DIGITS-5:0], cand}; digit_count increments, saturating at DIGITS.
- If digit_count==DIGITS before the shift, overflow←1.
- The pulse counter loads PULSE_LEN.

Clear:
- clear_entry=1 clears entry, digit_count and overflow, with priority over a same-cycle accept; that accept is discarded.
- clear_entry does not clear bcd.

Mode change:
- en=1 forces the FSM to IDLE, blocks accepts and clears the pulse counter.
- Entry contents are retained across mode changes.

pgt_tick:
- en=0: pgt_tick is high while the pulse counter is nonzero. The counter decrements each cycle. A new accept during a pulse reloads it (retrigger), so the high time is extended rather than a second edge produced.
- en=1: the divider counts 0..TICK_DIV-1, and pgt_tick is high for exactly one cycle when the count equals TICK_DIV-1. The divider is held at 0 while en=0, so the first tick occurs TICK_DIV cycles after en rises.
- Divider wrap: from TICK_DIV-1 the count returns to 0.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: the FSM stays in HELD after an accept, with a repeat counter. Each further REPEAT_CYC cycles of continuous hold generates another accept, with identical key_valid, entry shift and pulse reload. Release resets the repeat counter.
- Undefined: exactly one accept is generated per press, and REPEAT_CYC is ignored.

Decomposition:
Shared package keypad_pkg contains:
- BCD_W=4 and NO_KEY=4'hF;
- the debounce state enum {IDLE, CHECK, HELD, RELEASE};
- the function key_encode(10-bit) → 4-bit priority code.

One sub-module: key_debouncer. It contains the FSM, debounce counter and optional repeat logic, takes code and en as inputs, and outputs accept and cand. Entry register, pulse counter and divider stay in the top level.

Test Plan:
- Reset with keypad=0: all outputs 0, bcd=4'hF. Press key 5 with DEBOUNCE_CYC=8 → key_valid is seen 8 cycles after the press, bcd=5, entry=16'h0005, digit_count=1, pgt_tick high for 8 cycles.
- Key 3 bounces (3 cycles on, 1 off, repeated), then is held stable → exactly one accept, occurring only after 8 stable cycles.
- Enter 1,2,3,4,5 with DIGITS=4 → entry=16'h2345, digit_count=4, overflow=1. Then clear_entry → entry=0, digit_count=0, overflow=0.
- Keys 2 and 7 pressed together → bcd=7. Key accepted in the same cycle as clear_entry=1 → entry stays 0.
- en=1 with TICK_DIV=100 → pgt_tick is one cycle high at cycles 100, 200, 300. A key press while en=1 → no key_valid. Return to en=0 → entry retained.
- With KEYPAD_REPEAT_EN and REPEAT_CYC=64: hold key 9 for 8+64*3 cycles → 4 accepts, entry=16'h9999. Without the macro, the same hold gives 1 accept.
